sc_phase_sequencer: RTL and testbench
=====================================

Name: sc_phase_sequencer

Overview:
- Upstream game-phase sequencer for the RoadFighter display path.
- Produces the 2-bit phase code (CONTADOR) that the state-machine/mux-select stage consumes to choose between a cleared screen and the random road pattern.
- Also produces a prescaled scroll tick whose rate rises with level, and tracks start, crash and game-over timing.
- Sits between the board buttons/collision logic and the display select stage.

Parameters:
- PHASE_WIDTH, 2, width of the phase code output; must be >=2.
- PRESCALE_WIDTH, 24, width of the tick prescaler counter.
- PRESCALE_MAX, 12500000, base tick period in clocks at level 0; must be >=8.
- CLEAR_TICKS, 4, ticks spent in CLEAR before PLAY; must be >=1.
- LEVEL_STEPS, 16, PLAY ticks per level increment; must be >=1.
- GAMEOVER_TICKS, 8, ticks spent in GAMEOVER before IDLE; must be >=1.

Ports:
- SC_PHASESEQ_CLOCK_50  in  1  system clock, 50 MHz
- SC_PHASESEQ_RESET_InLow  in  1  asynchronous active-low reset
- SC_PHASESEQ_START_InLow  in  1  start push-button, active-low, asynchronous to clock
- SC_PHASESEQ_CRASH_InHigh  in  1  collision flag from game logic, synchronous, level
- SC_PHASESEQ_CONTADOR_Out  out  PHASE_WIDTH  phase code: 0 IDLE, 1 CLEAR, 2 PLAY, 3 GAMEOVER
- SC_PHASESEQ_TICK_Out  out  1  one-cycle scroll pulse
- SC_PHASESEQ_LEVEL_Out  out  2  current speed level, 0..3
- SC_PHASESEQ_BUSY_Out  out  1  high in CLEAR, PLAY and GAMEOVER

Behaviour:
- Reset: one clock; reset is asynchronous and active-low.
  - While SC_PHASESEQ_RESET_InLow=0: state IDLE, CONTADOR=0, TICK=0, LEVEL=0, BUSY=0.
  - All counters and the synchronizer flops are cleared; sync flops clear to 1 (button released).
  - Reset asserted mid-operation aborts immediately to IDLE, with no pulse on exit.
- Start input:
  - 2-flop synchronizer, then a third flop for edge detect.
  - press = synced 1->0 transition, a single-cycle event.
  - A held button yields exactly one press.
- Prescaler:
  - Runs only in CLEAR, PLAY and GAMEOVER.
  - Cleared to 0 on every state entry.
  - Counts 0..(PRESCALE_MAX>>LEVEL)-1; TICK=1 for one cycle on the terminal count, then wraps to 0.
  - LEVEL is the registered value; a level change takes effect from the next prescaler wrap.
  - TICK is always 0 in IDLE.
- FSM and outputs are registered; CONTADOR equals the state encoding.
  - IDLE: on press -> CLEAR next cycle. LEVEL cleared to 0.
  - CLEAR: count ticks; on the CLEAR_TICKS-th tick -> PLAY. A press here is ignored. CRASH is ignored.
  - PLAY, level progression:
    - Count ticks in a level-step counter.
    - On the LEVEL_STEPS-th tick, LEVEL increments (saturating at 3) and the step counter clears.
    - At LEVEL 3 the step counter still wraps; LEVEL holds.
  - PLAY, crash: CRASH=1 in any cycle -> GAMEOVER next cycle.
    - Crash wins over a simultaneous tick.
    - A simultaneous tick is still output, but does not advance the level.
  - PLAY, start: a press in PLAY -> CLEAR (restart), LEVEL cleared to 0. Crash has priority over a press.
  - GAMEOVER: count ticks; on the GAMEOVER_TICKS-th tick -> IDLE. LEVEL holds its last value until IDLE. A press is ignored.
- BUSY = (state != IDLE), registered alongside the state.
- Latency:
  - Button edge to CONTADOR=1: 4 clocks (2 sync, 1 edge, 1 state).
  - CRASH to CONTADOR=3: 1 clock.
- Width: the prescale reload computation uses PRESCALE_WIDTH bits; the shift never underflows because PRESCALE_MAX>=8.

Decomposition:
- Shared package sc_game_pkg holds:
  - phase enum/constants PHASE_IDLE=0, PHASE_CLEAR=1, PHASE_PLAY=2, PHASE_GAMEOVER=3 (also used by the select stage);
  - LEVEL_MAX=3.
- One natural sub-module: sc_tick_prescaler.
  - Contains the counter, clear-on-entry and shift-based reload.
  - Interface: clock, reset_n, enable, clear, level in; tick out.
- Synchronizer/edge detect and FSM stay in the top.

Test Plan:
- Bench parameters: PRESCALE_MAX=8, CLEAR_TICKS=2, LEVEL_STEPS=3, GAMEOVER_TICKS=2.
- Reset mid-PLAY, LEVEL=2: assert reset_n=0 asynchronously -> same-instant CONTADOR=0, LEVEL=0, TICK=0, BUSY=0; after release, stays IDLE with no tick.
- Start press from IDLE: START held low 20 cycles -> CONTADOR=1 exactly 4 clocks after the falling edge, only one press registered, TICK every 8 clocks, CONTADOR=2 on the cycle after the 2nd tick.
- Level ramp in PLAY -> tick spacing:
  - 8 clocks for 3 ticks, LEVEL=1;
  - 4 clocks for 3 ticks, LEVEL=2;
  - 2 clocks, LEVEL=3;
  - then 1 clock, LEVEL remains 3 thereafter.
- Crash coincident with tick at LEVEL=0, step count 2 -> next cycle CONTADOR=3, LEVEL stays 0; after 2 ticks CONTADOR=0, BUSY=0.
- Press and CRASH in the same PLAY cycle -> GAMEOVER (3), not CLEAR. A press during GAMEOVER and CLEAR -> no state change.
- Restart press in PLAY at LEVEL=2 -> CONTADOR=1, LEVEL=0, prescaler restarts (first tick 8 clocks after entry).

Source files
------------

// File: rtl/sc_game_pkg.sv
// Phase encoding and level limits shared by the phase sequencer and the display select stage.
// Pure definitions: no logic, no latency, no flow control.
package sc_game_pkg;

    typedef enum logic [1:0] {
        PHASE_IDLE     = 2'd0,
        PHASE_CLEAR    = 2'd1,
        PHASE_PLAY     = 2'd2,
        PHASE_GAMEOVER = 2'd3
    } phase_t;

    localparam logic [1:0] LEVEL_MAX = 2'd3;

endpackage

// File: rtl/sc_tick_prescaler.sv
// Level-scaled tick generator: period PRESCALE_MAX>>level clocks, first tick PRESCALE_MAX>>level clocks after clear.
// No backpressure; tick is a single-cycle strobe, gated off while disabled or clearing.
module sc_tick_prescaler #(
    parameter int PRESCALE_WIDTH = 24,
    parameter int PRESCALE_MAX   = 12500000
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       enable,
    input  logic       clear,
    input  logic [1:0] level,
    output logic       tick
);

    localparam logic [PRESCALE_WIDTH-1:0] BASE = PRESCALE_WIDTH'(PRESCALE_MAX);

    logic [PRESCALE_WIDTH-1:0] count;
    logic [PRESCALE_WIDTH-1:0] count_cur;
    logic [PRESCALE_WIDTH-1:0] term;
    logic                      terminal;
    logic                      tick_q;

    // The clear cycle itself counts as count 0, so the first tick lands a full period after entry.
    // ">=" keeps the counter in range when a level step shrinks the period.
    always_comb begin
        term      = (BASE >> level) - PRESCALE_WIDTH'(1);
        count_cur = clear ? '0 : count;
        terminal  = (count_cur >= term);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count  <= '0;
            tick_q <= 1'b0;
        end else if (!enable) begin
            count  <= '0;
            tick_q <= 1'b0;
        end else begin
            count  <= terminal ? '0 : count_cur + PRESCALE_WIDTH'(1);
            tick_q <= terminal;
        end
    end

    // A strobe left over from the previous phase must not leak into a new one or into IDLE.
    assign tick = tick_q & enable & ~clear;

endmodule

// File: rtl/sc_phase_sequencer.sv
// Game-phase FSM: synchronised start press -> CONTADOR=1 after 4 clocks, CRASH -> CONTADOR=3 after 1 clock.
// No backpressure; all inputs are sampled every cycle and outputs are registered.
module sc_phase_sequencer
    import sc_game_pkg::*;
#(
    parameter int PHASE_WIDTH    = 2,
    parameter int PRESCALE_WIDTH = 24,
    parameter int PRESCALE_MAX   = 12500000,
    parameter int CLEAR_TICKS    = 4,
    parameter int LEVEL_STEPS    = 16,
    parameter int GAMEOVER_TICKS = 8
) (
    input  logic                   SC_PHASESEQ_CLOCK_50,
    input  logic                   SC_PHASESEQ_RESET_InLow,
    input  logic                   SC_PHASESEQ_START_InLow,
    input  logic                   SC_PHASESEQ_CRASH_InHigh,
    output logic [PHASE_WIDTH-1:0] SC_PHASESEQ_CONTADOR_Out,
    output logic                   SC_PHASESEQ_TICK_Out,
    output logic [1:0]             SC_PHASESEQ_LEVEL_Out,
    output logic                   SC_PHASESEQ_BUSY_Out
);

    localparam int TICKS_MAX = (CLEAR_TICKS > GAMEOVER_TICKS) ? CLEAR_TICKS : GAMEOVER_TICKS;
    localparam int TW        = $clog2(TICKS_MAX + 1);
    localparam int SW        = $clog2(LEVEL_STEPS + 1);

    localparam logic [TW-1:0] CLEAR_LAST    = TW'(CLEAR_TICKS - 1);
    localparam logic [TW-1:0] GAMEOVER_LAST = TW'(GAMEOVER_TICKS - 1);
    localparam logic [SW-1:0] STEP_LAST     = SW'(LEVEL_STEPS - 1);

    logic          sync1, sync2, sync3;
    logic          press;
    phase_t        state;
    logic          busy;
    logic          entry;
    logic [1:0]    level;
    logic [TW-1:0] phase_ticks;
    logic [SW-1:0] steps;
    logic          tick;

    // Button is asynchronous: two flops to resolve, a third to see the falling edge, press registered.
    always_ff @(posedge SC_PHASESEQ_CLOCK_50 or negedge SC_PHASESEQ_RESET_InLow) begin
        if (!SC_PHASESEQ_RESET_InLow) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            sync3 <= 1'b1;
            press <= 1'b0;
        end else begin
            sync1 <= SC_PHASESEQ_START_InLow;
            sync2 <= sync1;
            sync3 <= sync2;
            press <= sync3 & ~sync2;
        end
    end

    sc_tick_prescaler #(
        .PRESCALE_WIDTH (PRESCALE_WIDTH),
        .PRESCALE_MAX   (PRESCALE_MAX)
    ) u_prescaler (
        .clock   (SC_PHASESEQ_CLOCK_50),
        .reset_n (SC_PHASESEQ_RESET_InLow),
        .enable  (busy),
        .clear   (entry),
        .level   (level),
        .tick    (tick)
    );

    always_ff @(posedge SC_PHASESEQ_CLOCK_50 or negedge SC_PHASESEQ_RESET_InLow) begin
        if (!SC_PHASESEQ_RESET_InLow) begin
            state       <= PHASE_IDLE;
            busy        <= 1'b0;
            entry       <= 1'b0;
            level       <= 2'd0;
            phase_ticks <= '0;
            steps       <= '0;
        end else begin
            entry <= 1'b0;
            case (state)
                PHASE_IDLE: begin
                    level <= 2'd0;
                    if (press) begin
                        state       <= PHASE_CLEAR;
                        busy        <= 1'b1;
                        entry       <= 1'b1;
                        phase_ticks <= '0;
                    end
                end
                PHASE_CLEAR: begin
                    if (tick) begin
                        if (phase_ticks == CLEAR_LAST) begin
                            state <= PHASE_PLAY;
                            entry <= 1'b1;
                            steps <= '0;
                        end else begin
                            phase_ticks <= phase_ticks + TW'(1);
                        end
                    end
                end
                PHASE_PLAY: begin
                    // Crash outranks both a restart press and a coincident level step.
                    if (SC_PHASESEQ_CRASH_InHigh) begin
                        state       <= PHASE_GAMEOVER;
                        entry       <= 1'b1;
                        phase_ticks <= '0;
                    end else if (press) begin
                        state       <= PHASE_CLEAR;
                        entry       <= 1'b1;
                        level       <= 2'd0;
                        phase_ticks <= '0;
                    end else if (tick) begin
                        if (steps == STEP_LAST) begin
                            steps <= '0;
                            if (level != LEVEL_MAX) level <= level + 2'd1;
                        end else begin
                            steps <= steps + SW'(1);
                        end
                    end
                end
                PHASE_GAMEOVER: begin
                    if (tick) begin
                        if (phase_ticks == GAMEOVER_LAST) begin
                            state <= PHASE_IDLE;
                            busy  <= 1'b0;
                            entry <= 1'b1;
                            level <= 2'd0;
                        end else begin
                            phase_ticks <= phase_ticks + TW'(1);
                        end
                    end
                end
                default: begin
                    state <= PHASE_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign SC_PHASESEQ_CONTADOR_Out = PHASE_WIDTH'(state);
    assign SC_PHASESEQ_TICK_Out     = tick;
    assign SC_PHASESEQ_LEVEL_Out    = level;
    assign SC_PHASESEQ_BUSY_Out     = busy;

endmodule

// File: tb/tb_sc_phase_sequencer.sv
// Directed bench for sc_phase_sequencer with an 8-clock base tick period.
module tb_sc_phase_sequencer;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b0;
    logic       start_n = 1'b1;
    logic       crash   = 1'b0;
    logic [1:0] contador;
    logic       tick;
    logic [1:0] level;
    logic       busy;

    int checks = 0;
    int errors = 0;

    sc_phase_sequencer #(
        .PHASE_WIDTH    (2),
        .PRESCALE_WIDTH (24),
        .PRESCALE_MAX   (8),
        .CLEAR_TICKS    (2),
        .LEVEL_STEPS    (3),
        .GAMEOVER_TICKS (2)
    ) dut (
        .SC_PHASESEQ_CLOCK_50     (clk),
        .SC_PHASESEQ_RESET_InLow  (rst_n),
        .SC_PHASESEQ_START_InLow  (start_n),
        .SC_PHASESEQ_CRASH_InHigh (crash),
        .SC_PHASESEQ_CONTADOR_Out (contador),
        .SC_PHASESEQ_TICK_Out     (tick),
        .SC_PHASESEQ_LEVEL_Out    (level),
        .SC_PHASESEQ_BUSY_Out     (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        start_n = 1'b1;
        crash   = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(2);
    endtask

    // Returns on the first cycle CONTADOR equals ph; timeout is a failed comparison.
    task automatic wait_phase(input logic [1:0] ph, input int budget, input string name);
        bit found = 1'b0;
        for (int i = 0; i < budget && !found; i++) begin
            step(1);
            if (contador === ph) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL %s: contador=%0d, never reached %0d in %0d cycles", name, contador, ph, budget);
        end
    endtask

    task automatic wait_tick(input int budget, input string name);
        bit found = 1'b0;
        for (int i = 0; i < budget && !found; i++) begin
            step(1);
            if (tick === 1'b1) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL %s: no tick within %0d cycles", name, budget);
        end
    endtask

    task automatic start_game();
        start_n = 1'b0;
        step(5);
        start_n = 1'b1;
        wait_phase(2'd2, 60, "start_game");
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step(2);
        checks++;
        if (contador !== 2'd0 || tick !== 1'b0 || level !== 2'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: contador=%0d tick=%0d level=%0d busy=%0d, required 0 0 0 0",
                     contador, tick, level, busy);
        end
        rst_n = 1'b1;
        step(5);
        checks++;
        if (contador !== 2'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: contador=%0d busy=%0d, required 0 0", contador, busy);
        end
    endtask

    // Falling edge at r=0; held 20 cycles. CLEAR from r=4, ticks at 12,20, PLAY at 21.
    // PLAY ticks: 29,37,45 (L0) 49,53,57 (L1) 59,61,63 (L2) then 65 and every cycle (L3).
    task automatic test_start_and_ramp();
        logic       exp_tick;
        logic [1:0] exp_level;
        do_reset();
        start_n = 1'b0;
        for (int r = 1; r <= 70; r++) begin
            step(1);
            if (r == 20) start_n = 1'b1;
            if (r == 3) begin
                checks++;
                if (contador !== 2'd0) begin
                    errors++;
                    $display("FAIL start_early: r=%0d contador=%0d, required 0", r, contador);
                end
            end
            if (r == 4) begin
                checks++;
                if (contador !== 2'd1 || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL start_latency: contador=%0d busy=%0d, required 1 1", contador, busy);
                end
            end
            if (r >= 5) begin
                exp_tick = (r == 12 || r == 20 || r == 29 || r == 37 || r == 45 || r == 49 ||
                            r == 53 || r == 57 || r == 59 || r == 61 || r == 63 || r >= 65);
                checks++;
                if (tick !== exp_tick) begin
                    errors++;
                    $display("FAIL ramp_tick: r=%0d tick=%0d, required %0d", r, tick, exp_tick);
                end
            end
            if (r == 21) begin
                checks++;
                if (contador !== 2'd2) begin
                    errors++;
                    $display("FAIL clear_to_play: contador=%0d, required 2", contador);
                end
            end
            if (r >= 22) begin
                exp_level = (r < 46) ? 2'd0 : (r < 58) ? 2'd1 : (r < 64) ? 2'd2 : 2'd3;
                checks++;
                if (level !== exp_level || contador !== 2'd2) begin
                    errors++;
                    $display("FAIL ramp_level: r=%0d level=%0d contador=%0d, required %0d 2",
                             r, level, contador, exp_level);
                end
            end
        end
    endtask

    task automatic test_reset_mid_play();
        bit found = 1'b0;
        do_reset();
        start_game();
        for (int i = 0; i < 100 && !found; i++) begin
            step(1);
            if (level === 2'd2) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL midreset_level: level=%0d never reached 2", level);
        end
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (contador !== 2'd0 || tick !== 1'b0 || level !== 2'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midreset_async: contador=%0d tick=%0d level=%0d busy=%0d, required 0 0 0 0",
                     contador, tick, level, busy);
        end
        step(2);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step(1);
            checks++;
            if (contador !== 2'd0 || tick !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL midreset_idle: cycle %0d contador=%0d tick=%0d busy=%0d, required 0 0 0",
                         i, contador, tick, busy);
            end
        end
    endtask

    // Third PLAY tick (step count 2) coincides with crash: no level step, GAMEOVER next cycle.
    task automatic test_crash_on_tick();
        do_reset();
        start_game();
        wait_tick(20, "crash_tick1");
        wait_tick(20, "crash_tick2");
        step(8);
        checks++;
        if (tick !== 1'b1 || level !== 2'd0) begin
            errors++;
            $display("FAIL crash_setup: tick=%0d level=%0d, required 1 0", tick, level);
        end
        crash = 1'b1;
        step(1);
        crash = 1'b0;
        checks++;
        if (contador !== 2'd3 || level !== 2'd0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL crash_gameover: contador=%0d level=%0d busy=%0d, required 3 0 1",
                     contador, level, busy);
        end
        step(16);
        checks++;
        if (contador !== 2'd3 || tick !== 1'b1) begin
            errors++;
            $display("FAIL gameover_ticks: contador=%0d tick=%0d, required 3 1", contador, tick);
        end
        step(1);
        checks++;
        if (contador !== 2'd0 || busy !== 1'b0 || level !== 2'd0 || tick !== 1'b0) begin
            errors++;
            $display("FAIL gameover_exit: contador=%0d busy=%0d level=%0d tick=%0d, required 0 0 0 0",
                     contador, busy, level, tick);
        end
    endtask

    task automatic test_press_vs_crash();
        do_reset();
        start_game();
        start_n = 1'b0;
        step(3);
        crash = 1'b1;
        step(1);
        crash = 1'b0;
        checks++;
        if (contador !== 2'd3) begin
            errors++;
            $display("FAIL press_crash_priority: contador=%0d, required 3", contador);
        end
        start_n = 1'b1;
        step(3);
        start_n = 1'b0;
        step(5);
        checks++;
        if (contador !== 2'd3) begin
            errors++;
            $display("FAIL press_in_gameover: contador=%0d, required 3", contador);
        end
        start_n = 1'b1;
        step(8);
        checks++;
        if (contador !== 2'd3 || tick !== 1'b1) begin
            errors++;
            $display("FAIL gameover_hold: contador=%0d tick=%0d, required 3 1", contador, tick);
        end
        step(1);
        checks++;
        if (contador !== 2'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL gameover_to_idle: contador=%0d busy=%0d, required 0 0", contador, busy);
        end
        start_n = 1'b0;
        step(4);
        checks++;
        if (contador !== 2'd1) begin
            errors++;
            $display("FAIL idle_press: contador=%0d, required 1", contador);
        end
        start_n = 1'b1;
        step(3);
        start_n = 1'b0;
        step(5);
        checks++;
        if (contador !== 2'd1) begin
            errors++;
            $display("FAIL press_in_clear: contador=%0d, required 1", contador);
        end
        start_n = 1'b1;
        step(8);
        checks++;
        if (contador !== 2'd1) begin
            errors++;
            $display("FAIL clear_hold: contador=%0d, required 1", contador);
        end
        step(1);
        checks++;
        if (contador !== 2'd2) begin
            errors++;
            $display("FAIL clear_timing_kept: contador=%0d, required 2", contador);
        end
    endtask

    // Level 2 first appears 37 cycles into PLAY; a press then lands in CLEAR 4 clocks later.
    task automatic test_restart_press();
        bit found = 1'b0;
        do_reset();
        start_game();
        for (int i = 0; i < 100 && !found; i++) begin
            step(1);
            if (level === 2'd2) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL restart_level: level=%0d never reached 2", level);
        end
        start_n = 1'b0;
        step(3);
        checks++;
        if (contador !== 2'd2 || level !== 2'd2) begin
            errors++;
            $display("FAIL restart_before: contador=%0d level=%0d, required 2 2", contador, level);
        end
        step(1);
        checks++;
        if (contador !== 2'd1 || level !== 2'd0 || busy !== 1'b1 || tick !== 1'b0) begin
            errors++;
            $display("FAIL restart_clear: contador=%0d level=%0d busy=%0d tick=%0d, required 1 0 1 0",
                     contador, level, busy, tick);
        end
        start_n = 1'b1;
        for (int r = 5; r <= 12; r++) begin
            step(1);
            checks++;
            if (tick !== (r == 12)) begin
                errors++;
                $display("FAIL restart_prescaler: r=%0d tick=%0d, required %0d", r, tick, (r == 12));
            end
        end
    endtask

    initial begin
        test_reset();
        test_start_and_ramp();
        test_reset_mid_play();
        test_crash_on_tick();
        test_press_vs_crash();
        test_restart_press();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
